store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 154 +++++++++++++++
 tb/tb_store_buffer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: 4-entry FIFO of posted CPU stores (SW/SH/SB) drained to data memory one word at a time.
// Optional macro SB_MISALIGN_TRAP_EN rejects misaligned SH/SW and pulses misalign for one cycle.
module store_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    input  logic [5:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_wdata,
    output logic        st_ready,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        ld_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    output logic        empty,
    output logic        misalign
);

    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SW = 6'b101011;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    logic [29:0] r_word  [4];
    logic [31:0] r_data  [4];
    logic [3:0]  r_be    [4];
    logic [3:0]  r_valid;
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_count;
    state_t      r_state;

    logic        w_is_store;
    logic        w_misaligned;
    logic        w_enq;
    logic        w_pop;
    logic        w_hit;
    logic [3:0]  w_be;
    logic [31:0] w_data;
    logic [2:0]  w_count_next;
    logic [1:0]  w_unused_ld;

    // Lane steering: data is replicated so the byte enables alone select the bytes written.
    always_comb begin
        w_is_store = 1'b1;
        w_be       = 4'b0000;
        w_data     = 32'h0;
        case (st_op)
            OP_SW: begin
                w_be   = 4'b1111;
                w_data = st_wdata;
            end
            OP_SH: begin
                w_be   = st_addr[1] ? 4'b1100 : 4'b0011;
                w_data = {2{st_wdata[15:0]}};
            end
            OP_SB: begin
                w_be   = 4'b0001 << st_addr[1:0];
                w_data = {4{st_wdata[7:0]}};
            end
            default: w_is_store = 1'b0;
        endcase
    end

`ifdef SB_MISALIGN_TRAP_EN
    assign w_misaligned = ((st_op == OP_SH) && st_addr[0]) ||
                          ((st_op == OP_SW) && (st_addr[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    assign st_ready     = (r_count != 3'd4);
    assign w_enq        = st_valid && st_ready && w_is_store && !w_misaligned;
    assign w_pop        = (r_state == BUSY) && mem_ack;
    assign w_count_next = r_count + {2'b00, w_enq} - {2'b00, w_pop};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_word[i] <= '0;
                r_data[i] <= '0;
                r_be[i]   <= '0;
            end
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + 2'd1;
            end
            if (w_enq) begin
                r_word[r_wr_ptr]  <= st_addr[31:2];
                r_data[r_wr_ptr]  <= w_data;
                r_be[r_wr_ptr]    <= w_be;
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + 2'd1;
            end
            r_count <= w_count_next;
        end
    end

    // Drain FSM: IDLE waits one edge after the first store lands, BUSY presents the head until acked.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: if (r_count != 3'd0) r_state <= BUSY;
                BUSY: if (w_pop && (w_count_next == 3'd0)) r_state <= IDLE;
            endcase
        end
    end

    assign mem_req   = (r_state == BUSY);
    assign mem_addr  = mem_req ? {r_word[r_rd_ptr], 2'b00} : 32'h0;
    assign mem_wdata = mem_req ? r_data[r_rd_ptr] : 32'h0;
    assign mem_be    = mem_req ? r_be[r_rd_ptr] : 4'b0000;
    assign empty     = (r_count == 3'd0);

    // Loads hazard at word granularity, so the byte offset of the load never matters.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (r_valid[i] && (r_word[i] == ld_addr[31:2])) w_hit = 1'b1;
        end
    end

    assign ld_stall    = ld_valid && w_hit;
    assign w_unused_ld = ld_addr[1:0];

`ifdef SB_MISALIGN_TRAP_EN
    logic r_misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= st_valid && st_ready && w_is_store && w_misaligned;
        end
    end

    assign misalign = r_misalign;
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: scoreboard bench for store_buffer; expected memory writes are queued on accepted
// stores and compared by a monitor whenever the DUT's write is acknowledged.
module tb_store_buffer;

    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_LW = 6'b100011;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        st_valid = 1'b0;
    logic [5:0]  st_op    = 6'h0;
    logic [31:0] st_addr  = 32'h0;
    logic [31:0] st_wdata = 32'h0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_addr  = 32'h0;
    logic        mem_ack  = 1'b0;
    logic        st_ready;
    logic        ld_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        empty;
    logic        misalign;

    store_buffer dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_op(st_op), .st_addr(st_addr), .st_wdata(st_wdata), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_stall(ld_stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
        .empty(empty), .misalign(misalign)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   errors   = 0;
    wr_t  sbQ[$];
    wr_t  monWr;
    int   expCount = 0;
    logic expBusy  = 1'b0;
    logic expMis   = 1'b0;
    logic mStore, mRej, mEnq, mPop;

    function automatic wr_t expect_write(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = {a[31:2], 2'b00};
        case (op)
            OP_SW:   begin w.be = 4'b1111; w.data = d; end
            OP_SH:   begin w.be = a[1] ? 4'b1100 : 4'b0011; w.data = {d[15:0], d[15:0]}; end
            default: begin
                case (a[1:0])
                    2'd0: w.be = 4'b0001;
                    2'd1: w.be = 4'b0010;
                    2'd2: w.be = 4'b0100;
                    default: w.be = 4'b1000;
                endcase
                w.data = {d[7:0], d[7:0], d[7:0], d[7:0]};
            end
        endcase
        return w;
    endfunction

    // Reference model of occupancy and drain state, driven only by bench stimulus.
    always_comb begin
        mStore = (st_op == OP_SW) || (st_op == OP_SH) || (st_op == OP_SB);
`ifdef SB_MISALIGN_TRAP_EN
        mRej = mStore && (((st_op == OP_SH) && st_addr[0]) || ((st_op == OP_SW) && (st_addr[1:0] != 2'b00)));
`else
        mRej = 1'b0;
`endif
        mEnq = st_valid && mStore && (expCount != 4) && !mRej;
        mPop = expBusy && mem_ack;
    end

    always @(posedge clk) begin
        if (rst) begin
            expCount <= 0;
            expBusy  <= 1'b0;
            expMis   <= 1'b0;
            sbQ.delete();
        end else begin
            expCount <= expCount + int'(mEnq) - int'(mPop);
            if (!expBusy) expBusy <= (expCount != 0);
            else if (mPop && ((expCount + int'(mEnq) - int'(mPop)) == 0)) expBusy <= 1'b0;
            expMis <= st_valid && mStore && (expCount != 4) && mRej;
            if (mEnq) sbQ.push_back(expect_write(st_op, st_addr, st_wdata));
        end
    end

    // Monitor: every acknowledged write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst === 1'b0 && mem_req === 1'b1 && mem_ack === 1'b1) begin
            checks++;
            if (sbQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write: got addr=%h data=%h be=%b, required no write", mem_addr, mem_wdata, mem_be);
            end else begin
                monWr = sbQ.pop_front();
                if (mem_addr !== monWr.addr || mem_wdata !== monWr.data || mem_be !== monWr.be) begin
                    errors++;
                    $display("[TB] FAIL mem_write: got addr=%h data=%h be=%b, required addr=%h data=%h be=%b",
                             mem_addr, mem_wdata, mem_be, monWr.addr, monWr.data, monWr.be);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        ld_valid = 1'b1;
        ld_addr = 32'h0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_mem_req: got %b required 0", mem_req); end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL rst_empty: got %b required 1", empty); end
        checks++; if (st_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_st_ready: got %b required 1", st_ready); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("[TB] FAIL rst_misalign: got %b required 0", misalign); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL rst_mem_addr: got %h required 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_mem_wdata: got %h required 0", mem_wdata); end
        checks++; if (mem_be !== 4'h0) begin errors++; $display("[TB] FAIL rst_mem_be: got %b required 0000", mem_be); end
        checks++; if (ld_stall !== 1'b0) begin errors++; $display("[TB] FAIL rst_ld_stall: got %b required 0", ld_stall); end
        ld_valid = 1'b0;
        tick();
    endtask

    task automatic test_sb_lane();
        st_valid = 1'b1; st_op = OP_SB; st_addr = 32'h103; st_wdata = 32'h000000AB;
        tick();
        st_valid = 1'b0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL sb_req_early: got %b required 0", mem_req); end
        checks++; if (empty !== 1'b0) begin errors++; $display("[TB] FAIL sb_empty: got %b required 0", empty); end
        tick();
        @(negedge clk);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL sb_req: got %b required 1", mem_req); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("[TB] FAIL sb_addr: got %h required 00000100", mem_addr); end
        checks++; if (mem_be !== 4'b1000) begin errors++; $display("[TB] FAIL sb_be: got %b required 1000", mem_be); end
        checks++; if (mem_wdata !== 32'hABABABAB) begin errors++; $display("[TB] FAIL sb_wdata: got %h required ababab ab", mem_wdata); end
        tick();
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("[TB] FAIL sb_hold: got req=%b addr=%h required req=1 addr=00000100", mem_req, mem_addr); end
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL sb_idle: got %b required 0", mem_req); end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL sb_drained: got %b required 1", empty); end
        checks++; if (sbQ.size() != 0) begin errors++; $display("[TB] FAIL sb_outstanding: got %0d required 0", sbQ.size()); end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 5; k++) begin
            st_valid = 1'b1; st_op = OP_SW; st_addr = 32'h1000 + 32'(4 * k); st_wdata = $urandom;
            @(negedge clk);
            checks++; if (st_ready !== (k < 4)) begin errors++; $display("[TB] FAIL b2b_ready_%0d: got %b required %b", k, st_ready, (k < 4)); end
            tick();
        end
        st_valid = 1'b0;
        mem_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL b2b_req_%0d: got %b required 1", k, mem_req); end
            tick();
        end
        mem_ack = 1'b0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle: got %b required 0", mem_req); end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL b2b_empty: got %b required 1", empty); end
        checks++; if (sbQ.size() != 0) begin errors++; $display("[TB] FAIL b2b_outstanding: got %0d required 0", sbQ.size()); end
        tick();
    endtask

    task automatic test_ld_hazard();
        st_valid = 1'b1; st_op = OP_SH; st_addr = 32'h202; st_wdata = 32'h00001234;
        tick();
        st_valid = 1'b0;
        ld_valid = 1'b1; ld_addr = 32'h200;
        @(negedge clk);
        checks++; if (ld_stall !== 1'b1) begin errors++; $display("[TB] FAIL ld_same_word: got %b required 1", ld_stall); end
        ld_addr = 32'h204;
        #1;
        checks++; if (ld_stall !== 1'b0) begin errors++; $display("[TB] FAIL ld_next_word: got %b required 0", ld_stall); end
        ld_addr = 32'h203;
        #1;
        checks++; if (ld_stall !== 1'b1) begin errors++; $display("[TB] FAIL ld_byte_in_word: got %b required 1", ld_stall); end
        ld_valid = 1'b0;
        #1;
        checks++; if (ld_stall !== 1'b0) begin errors++; $display("[TB] FAIL ld_no_valid: got %b required 0", ld_stall); end
        ld_valid = 1'b1; ld_addr = 32'h200;
        tick();
        @(negedge clk);
        checks++; if (ld_stall !== 1'b1) begin errors++; $display("[TB] FAIL ld_busy: got %b required 1", ld_stall); end
        checks++; if (mem_be !== 4'b1100 || mem_wdata !== 32'h12341234) begin errors++; $display("[TB] FAIL sh_lane: got be=%b data=%h required be=1100 data=12341234", mem_be, mem_wdata); end
        tick();
        mem_ack = 1'b1;
        @(negedge clk);
        checks++; if (ld_stall !== 1'b1) begin errors++; $display("[TB] FAIL ld_before_pop: got %b required 1", ld_stall); end
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        checks++; if (ld_stall !== 1'b0) begin errors++; $display("[TB] FAIL ld_after_pop: got %b required 0", ld_stall); end
        ld_valid = 1'b0;
        tick();
    endtask

    task automatic test_full_with_pop();
        for (int k = 0; k < 4; k++) begin
            st_valid = 1'b1; st_op = OP_SW; st_addr = 32'h3000 + 32'(4 * k); st_wdata = 32'h11110000 + 32'(k);
            tick();
        end
        st_valid = 1'b1; st_op = OP_SW; st_addr = 32'h3010; st_wdata = 32'hDEADBEEF;
        mem_ack = 1'b1;
        @(negedge clk);
        checks++; if (st_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready: got %b required 0", st_ready); end
        tick();
        st_valid = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        checks++; if (st_ready !== 1'b1 || empty !== 1'b0) begin errors++; $display("[TB] FAIL full_pop_count: got ready=%b empty=%b required ready=1 empty=0", st_ready, empty); end
        checks++; if (mem_addr !== 32'h3004) begin errors++; $display("[TB] FAIL full_next_head: got %h required 00003004", mem_addr); end
        tick();
        mem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL full_drain_%0d: got %b required 1", k, mem_req); end
            tick();
        end
        mem_ack = 1'b0;
        @(negedge clk);
        checks++; if (empty !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("[TB] FAIL full_end: got empty=%b req=%b required empty=1 req=0", empty, mem_req); end
        checks++; if (sbQ.size() != 0) begin errors++; $display("[TB] FAIL full_outstanding: got %0d required 0", sbQ.size()); end
        tick();
    endtask

    task automatic test_reset_busy();
        for (int k = 0; k < 3; k++) begin
            st_valid = 1'b1; st_op = OP_SW; st_addr = 32'h5000 + 32'(4 * k); st_wdata = $urandom;
            tick();
        end
        st_valid = 1'b0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL rb_busy: got %b required 1", mem_req); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0 || empty !== 1'b1) begin errors++; $display("[TB] FAIL rb_cleared: got req=%b empty=%b required req=0 empty=1", mem_req, empty); end
        checks++; if (mem_addr !== 32'h0 || st_ready !== 1'b1) begin errors++; $display("[TB] FAIL rb_outputs: got addr=%h ready=%b required addr=0 ready=1", mem_addr, st_ready); end
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0 || empty !== 1'b1) begin errors++; $display("[TB] FAIL rb_late_ack: got req=%b empty=%b required req=0 empty=1", mem_req, empty); end
        tick();
    endtask

    task automatic test_mixed_lanes();
        logic [5:0]  ops   [8] = '{OP_SB, OP_SB, OP_SB, OP_SH, OP_SH, OP_LW, OP_SB, OP_SH};
        logic [31:0] addrs [8] = '{32'h400, 32'h401, 32'h402, 32'h400, 32'h402, 32'h400, 32'h403, 32'h403};
        logic [31:0] datas [8] = '{32'h11, 32'h22, 32'h33, 32'h4455, 32'h6677, 32'hFFFF, 32'h88, 32'h9999};
        mem_ack = 1'b1;
        for (int k = 0; k < 8; k++) begin
            st_valid = 1'b1; st_op = ops[k]; st_addr = addrs[k]; st_wdata = datas[k];
            @(negedge clk);
            checks++; if (st_ready !== (expCount != 4)) begin errors++; $display("[TB] FAIL mix_ready_%0d: got %b required %b", k, st_ready, (expCount != 4)); end
            tick();
        end
        st_valid = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        mem_ack = 1'b0;
        @(negedge clk);
        checks++; if (empty !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("[TB] FAIL mix_end: got empty=%b req=%b required empty=1 req=0", empty, mem_req); end
        checks++; if (sbQ.size() != 0) begin errors++; $display("[TB] FAIL mix_outstanding: got %0d required 0", sbQ.size()); end
        tick();
    endtask

    task automatic test_misalign();
        st_valid = 1'b1; st_op = OP_SW; st_addr = 32'h101; st_wdata = 32'hCAFEBABE;
        tick();
        st_valid = 1'b0;
        @(negedge clk);
`ifdef SB_MISALIGN_TRAP_EN
        checks++; if (misalign !== 1'b1) begin errors++; $display("[TB] FAIL mis_pulse: got %b required 1", misalign); end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL mis_no_enq: got %b required 1", empty); end
        tick();
        @(negedge clk);
        checks++; if (misalign !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("[TB] FAIL mis_one_cycle: got mis=%b req=%b required 0 0", misalign, mem_req); end
`else
        checks++; if (misalign !== expMis) begin errors++; $display("[TB] FAIL mis_tied: got %b required %b", misalign, expMis); end
        tick();
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("[TB] FAIL mis_addr: got req=%b addr=%h required req=1 addr=00000100", mem_req, mem_addr); end
        checks++; if (mem_be !== 4'b1111) begin errors++; $display("[TB] FAIL mis_be: got %b required 1111", mem_be); end
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL mis_drained: got %b required 1", empty); end
`endif
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_sb_lane();
        test_back_to_back();
        test_ld_hazard();
        test_full_with_pop();
        test_reset_busy();
        test_mixed_lanes();
        test_misalign();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
